// File: rtl/dsp_mac_sequencer_if.sv
// Operand stream interface for dsp_mac_sequencer.
//   in_valid : producer has an operand pair on in_a/in_b
//   in_a     : signed 18-bit operand A
//   in_b     : signed 18-bit operand B
//   in_ready : sequencer accepts the pair this cycle
// master = operand producer, slave = sequencer.
interface dsp_mac_sequencer_if;
    logic        in_valid;
    logic [17:0] in_a;
    logic [17:0] in_b;
    logic        in_ready;

    modport master (output in_valid, output in_a, output in_b, input in_ready);
    modport slave  (input in_valid, input in_a, input in_b, output in_ready);
endinterface

// File: rtl/dsp_mac_sequencer.sv
// Control FSM that runs one DSP48A1 slice (A1REG=B1REG=MREG=PREG=OPMODEREG=1,
// CARRYINSEL=OPMODE5) as a signed multiply-accumulate engine.
// Ports:
//   CLK, RST_N          clock, asynchronous active-low reset
//   start, len, abort   job control (start/len sampled in IDLE)
//   in_if               operand stream (slave side)
//   dsp_a/b, dsp_opmode, dsp_ce*, dsp_rst*   slice controls
//   dsp_p, dsp_carryout slice outputs
//   result, result_valid, overflow, busy     job result and status
module dsp_mac_sequencer #(
    parameter int unsigned LEN_W      = 8,
    parameter bit          USE_C_INIT = 1'b0
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 start,
    input  logic [LEN_W-1:0]     len,
    input  logic                 abort,
    dsp_mac_sequencer_if.slave   in_if,
    output logic [17:0]          dsp_a,
    output logic [17:0]          dsp_b,
    output logic [7:0]           dsp_opmode,
    output logic                 dsp_cea,
    output logic                 dsp_ceb,
    output logic                 dsp_cem,
    output logic                 dsp_ceopmode,
    output logic                 dsp_cep,
    output logic                 dsp_rstm,
    output logic                 dsp_rstp,
    input  logic [47:0]          dsp_p,
    input  logic                 dsp_carryout,
    output logic [47:0]          result,
    output logic                 result_valid,
    output logic                 overflow,
    output logic                 busy
);

    // First pair loads Z=0 or Z=C; later pairs accumulate Z=P, X=M.
    localparam logic [7:0] OPM0    = USE_C_INIT ? 8'h0D : 8'h01;
    localparam logic [7:0] OPM_ACC = 8'h09;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t             state, state_nx;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   count;
    logic [7:0]         opmode_q;
    logic               rst_q;
    logic [47:0]        result_q;
    logic               ovf_q;
    // Tag pipe: t1 = M stage (CEM), t2 = P stage (CEP), t3 = P/CARRYOUT readable.
    logic               t1_v, t1_last, t2_v, t2_last, t3_v, t3_last;

    logic               accept;
    logic               last_acc;
    logic               abort_hit;

    assign abort_hit = abort && (state == S_RUN || state == S_DRAIN);
    assign accept    = (state == S_RUN) && in_if.in_valid;
    // Compare against len-1 so len = 2**LEN_W-1 never needs count to wrap.
    assign last_acc  = accept && (count == len_q - LEN_W'(1));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = (len != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (abort_hit) begin
                    state_nx = S_IDLE;
                end else if (last_acc) begin
                    state_nx = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Last tag is in t3 when t1/t2 are empty; result lands this edge.
                if (abort_hit) begin
                    state_nx = S_IDLE;
                end else if (!t1_v && !t2_v) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            len_q    <= '0;
            count    <= '0;
            opmode_q <= '0;
            rst_q    <= 1'b1;
            result_q <= '0;
            ovf_q    <= 1'b0;
            t1_v     <= 1'b0;
            t1_last  <= 1'b0;
            t2_v     <= 1'b0;
            t2_last  <= 1'b0;
            t3_v     <= 1'b0;
            t3_last  <= 1'b0;
        end else begin
            rst_q <= abort_hit;

            if (state == S_IDLE && start) begin
                len_q <= len;
                count <= '0;
                ovf_q <= 1'b0;
                if (len == '0) begin
                    result_q <= '0;
                end
            end

            if (accept && !abort_hit) begin
                count    <= count + LEN_W'(1);
                opmode_q <= (count == '0) ? OPM0 : OPM_ACC;
            end

            if (abort_hit) begin
                t1_v    <= 1'b0;
                t1_last <= 1'b0;
                t2_v    <= 1'b0;
                t2_last <= 1'b0;
                t3_v    <= 1'b0;
                t3_last <= 1'b0;
            end else begin
                t1_v    <= accept;
                t1_last <= last_acc;
                t2_v    <= t1_v;
                t2_last <= t1_last;
                t3_v    <= t2_v;
                t3_last <= t2_last;
            end

            if (t3_v && !abort_hit) begin
                ovf_q <= ovf_q | dsp_carryout;
                if (t3_last) begin
                    result_q <= dsp_p;
                end
            end
        end
    end

    assign in_if.in_ready = (state == S_RUN);
    assign dsp_a          = in_if.in_a;
    assign dsp_b          = in_if.in_b;
    assign dsp_opmode     = opmode_q;
    assign dsp_cea        = accept;
    assign dsp_ceb        = accept;
    assign dsp_cem        = t1_v;
    assign dsp_ceopmode   = t1_v;
    assign dsp_cep        = t2_v;
    assign dsp_rstm       = rst_q;
    assign dsp_rstp       = rst_q;
    assign result         = result_q;
    assign result_valid   = (state == S_DONE);
    assign overflow       = ovf_q;
    assign busy           = (state != S_IDLE);

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Testbench for dsp_mac_sequencer: two instances (USE_C_INIT=0 and 1) share
// the same stimulus, each driving its own behavioural DSP48A1 slice model.
// Expected results are queued per instance when a job starts and checked
// when result_valid pulses.
module tb_dsp_mac_sequencer;
    localparam int unsigned LEN_W = 8;

    typedef struct {
        logic [47:0] res;
        logic        ovf;
        int unsigned n;
    } exp_t;

    logic             CLK = 1'b0;
    logic             RST_N;
    logic             start;
    logic             abort;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic [17:0]      in_a;
    logic [17:0]      in_b;
    logic [47:0]      c_val;

    logic        in_ready [2];
    logic [17:0] dsp_a [2];
    logic [17:0] dsp_b [2];
    logic [7:0]  opmode [2];
    logic        cea [2];
    logic        ceb [2];
    logic        cem [2];
    logic        ceop [2];
    logic        cep [2];
    logic        rstm [2];
    logic        rstp [2];
    logic [47:0] p [2];
    logic        co [2];
    logic [47:0] result [2];
    logic        rv [2];
    logic        ovf [2];
    logic        busy [2];

    // slice model state
    logic [17:0] a_r [2];
    logic [17:0] b_r [2];
    logic [35:0] m_r [2];
    logic [7:0]  op_r [2];

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;
    exp_t        sb0 [$];
    exp_t        sb1 [$];
    int unsigned cem_cnt [2];
    int unsigned cep_cnt [2];
    int unsigned start_cyc [2];
    int unsigned last_acc [2];
    logic        first_pend [2];
    logic [17:0] pa [256];
    logic [17:0] pb [256];

    dsp_mac_sequencer_if sif0 ();
    dsp_mac_sequencer_if sif1 ();

    assign sif0.in_valid = in_valid;
    assign sif0.in_a     = in_a;
    assign sif0.in_b     = in_b;
    assign sif1.in_valid = in_valid;
    assign sif1.in_a     = in_a;
    assign sif1.in_b     = in_b;
    assign in_ready[0]   = sif0.in_ready;
    assign in_ready[1]   = sif1.in_ready;

    dsp_mac_sequencer #(.LEN_W(LEN_W), .USE_C_INIT(1'b0)) dut0 (
        .CLK(CLK), .RST_N(RST_N), .start(start), .len(len), .abort(abort),
        .in_if(sif0),
        .dsp_a(dsp_a[0]), .dsp_b(dsp_b[0]), .dsp_opmode(opmode[0]),
        .dsp_cea(cea[0]), .dsp_ceb(ceb[0]), .dsp_cem(cem[0]), .dsp_ceopmode(ceop[0]),
        .dsp_cep(cep[0]), .dsp_rstm(rstm[0]), .dsp_rstp(rstp[0]),
        .dsp_p(p[0]), .dsp_carryout(co[0]),
        .result(result[0]), .result_valid(rv[0]), .overflow(ovf[0]), .busy(busy[0])
    );

    dsp_mac_sequencer #(.LEN_W(LEN_W), .USE_C_INIT(1'b1)) dut1 (
        .CLK(CLK), .RST_N(RST_N), .start(start), .len(len), .abort(abort),
        .in_if(sif1),
        .dsp_a(dsp_a[1]), .dsp_b(dsp_b[1]), .dsp_opmode(opmode[1]),
        .dsp_cea(cea[1]), .dsp_ceb(ceb[1]), .dsp_cem(cem[1]), .dsp_ceopmode(ceop[1]),
        .dsp_cep(cep[1]), .dsp_rstm(rstm[1]), .dsp_rstp(rstp[1]),
        .dsp_p(p[1]), .dsp_carryout(co[1]),
        .result(result[1]), .result_valid(rv[1]), .overflow(ovf[1]), .busy(busy[1])
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [35:0] mul18(input logic [17:0] a, input logic [17:0] b);
        logic signed [35:0] r;
        r = $signed(a) * $signed(b);
        return r;
    endfunction

    // Returns {carry, P}. Carry comes from adding the 36-bit product unextended.
    function automatic logic [48:0] post_add(input logic [7:0] op, input logic [35:0] m,
                                             input logic [47:0] pv, input logic [47:0] cv);
        logic [47:0] z;
        logic [47:0] x;
        logic [48:0] s;
        logic [48:0] t;
        case (op[3:2])
            2'b10:   z = pv;
            2'b11:   z = cv;
            default: z = '0;
        endcase
        x = (op[1:0] == 2'b01) ? {{12{m[35]}}, m} : '0;
        s = {1'b0, z} + {1'b0, x};
        t = {1'b0, z} + {13'b0, m};
        return {t[48], s[47:0]};
    endfunction

    // Behavioural DSP48A1 slice, one per instance.
    always @(posedge CLK) begin
        for (int unsigned i = 0; i < 2; i++) begin
            if (cea[i]) a_r[i] <= dsp_a[i];
            if (ceb[i]) b_r[i] <= dsp_b[i];
            if (rstm[i]) m_r[i] <= '0;
            else if (cem[i]) m_r[i] <= mul18(a_r[i], b_r[i]);
            if (ceop[i]) op_r[i] <= opmode[i];
            if (rstp[i]) begin
                p[i]  <= '0;
                co[i] <= 1'b0;
            end else if (cep[i]) begin
                {co[i], p[i]} <= post_add(op_r[i], m_r[i], p[i], c_val);
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic score(input int unsigned i);
        exp_t e;
        logic empty;
        if (start && !busy[i]) begin
            cem_cnt[i]    = 0;
            cep_cnt[i]    = 0;
            first_pend[i] = 1'b1;
            start_cyc[i]  = cyc;
        end
        if (cea[i]) last_acc[i] = cyc;
        if (cem[i]) begin
            cem_cnt[i]++;
            if (first_pend[i]) begin
                check("opmode_first", 64'(opmode[i]), (i == 0) ? 64'h01 : 64'h0D);
                first_pend[i] = 1'b0;
            end else begin
                check("opmode_acc", 64'(opmode[i]), 64'h09);
            end
        end
        if (cep[i]) cep_cnt[i]++;
        if (rv[i]) begin
            empty = (i == 0) ? (sb0.size() == 0) : (sb1.size() == 0);
            if (empty) begin
                check("rv_spurious", 64'(rv[i]), 64'd0);
            end else begin
                if (i == 0) e = sb0.pop_front();
                else        e = sb1.pop_front();
                check("result", 64'(result[i]), 64'(e.res));
                check("overflow", 64'(ovf[i]), 64'(e.ovf));
                check("cep_count", 64'(cep_cnt[i]), 64'(e.n));
                check("cem_count", 64'(cem_cnt[i]), 64'(e.n));
                if (e.n == 0) check("latency_len0", 64'(cyc - start_cyc[i]), 64'd1);
                else          check("latency", 64'(cyc - last_acc[i]), 64'd4);
            end
        end
    endtask

    always @(negedge CLK) begin
        if (RST_N) begin
            score(0);
            score(1);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_idle();
        for (int unsigned w = 0; w < 30; w++) begin
            if (!busy[0] && !busy[1]) break;
            tick();
        end
        check("idle0", 64'(busy[0]), 64'd0);
        check("idle1", 64'(busy[1]), 64'd0);
    endtask

    // Starts a job on pa/pb[0..n-1]; gap idle cycles between pairs; noise
    // re-asserts start while busy; with_abort raises abort alongside start.
    task automatic run_job(input int unsigned n, input int unsigned gap, input logic o0,
                           input logic o1, input logic noise, input logic with_abort);
        exp_t        e;
        logic [47:0] acc = '0;
        logic [35:0] pr;
        for (int unsigned k = 0; k < n; k++) begin
            pr  = mul18(pa[k], pb[k]);
            acc = acc + {{12{pr[35]}}, pr};
        end
        e.n   = n;
        e.res = acc;
        e.ovf = o0;
        sb0.push_back(e);
        e.res = acc + c_val;
        e.ovf = o1;
        sb1.push_back(e);
        start = 1'b1;
        abort = with_abort;
        len   = LEN_W'(n);
        tick();
        start = 1'b0;
        abort = 1'b0;
        for (int unsigned k = 0; k < n; k++) begin
            in_valid = 1'b1;
            in_a     = pa[k];
            in_b     = pb[k];
            if (noise) begin
                start = 1'b1;
                len   = 8'd5;
            end
            check("in_ready", 64'(in_ready[0]), 64'd1);
            tick();
            in_valid = 1'b0;
            if (k + 1 < n) begin
                for (int unsigned g = 0; g < gap; g++) begin
                    check("ready_gap", 64'(in_ready[0]), 64'd1);
                    tick();
                end
            end
        end
        start = 1'b0;
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        RST_N    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        len      = '0;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        c_val    = '0;
        repeat (3) tick();

        // reset state
        check("rst_busy", 64'(busy[0]), 64'd0);
        check("rst_rstm", 64'(rstm[0]), 64'd1);
        check("rst_rstp", 64'(rstp[1]), 64'd1);
        check("rst_result", 64'(result[0]), 64'd0);
        check("rst_rv", 64'(rv[0]), 64'd0);
        check("rst_ready", 64'(in_ready[0]), 64'd0);
        check("rst_opmode", 64'(opmode[1]), 64'd0);
        check("rst_cep", 64'(cep[0]), 64'd0);
        @(posedge CLK);
        #3;
        RST_N = 1'b1;
        #1;
        check("rstm_hold", 64'(rstm[0]), 64'd1);
        tick();
        check("rstm_drop", 64'(rstm[0]), 64'd0);
        check("rstp_drop", 64'(rstp[1]), 64'd0);
        tick();

        // back-to-back dot product
        pa[0] = 18'd2; pb[0] = 18'd3;
        pa[1] = 18'd4; pb[1] = 18'd5;
        pa[2] = -18'sd1; pb[2] = 18'd7;
        run_job(3, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // same pairs with 2-cycle bubbles, start pulsed while busy
        run_job(3, 2, 1'b0, 1'b0, 1'b1, 1'b0);

        // C-port initial value
        c_val = 48'd100;
        pa[0] = 18'd10; pb[0] = 18'd10;
        run_job(1, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // wrap through C = -1
        c_val = 48'hFFFF_FFFF_FFFF;
        pa[0] = 18'd1; pb[0] = 18'd1;
        run_job(1, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        c_val = '0;

        // zero-length job
        run_job(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // abort after 2 accepts of a len=4 job
        start = 1'b1;
        len   = 8'd4;
        tick();
        start = 1'b0;
        for (int unsigned k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            in_a     = 18'd7;
            in_b     = 18'd9;
            tick();
        end
        in_valid = 1'b0;
        abort    = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_rstm", 64'(rstm[0]), 64'd1);
        check("abort_rstp", 64'(rstp[1]), 64'd1);
        check("abort_idle", 64'(busy[0]), 64'd0);
        check("abort_keep0", 64'(result[0]), 64'd0);
        check("abort_keep1", 64'(result[1]), 64'd0);
        tick();
        check("abort_rstm_drop", 64'(rstm[0]), 64'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_idle_ignored", 64'(rstm[1]), 64'd0);
        pa[0] = 18'd3; pb[0] = 18'd3;
        run_job(1, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // maximum length job
        for (int unsigned k = 0; k < 255; k++) begin
            pa[k] = 18'($urandom_range(1, 100));
            pb[k] = 18'($urandom_range(1, 100));
        end
        run_job(255, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // reset while draining
        start = 1'b1;
        len   = 8'd2;
        tick();
        start = 1'b0;
        for (int unsigned k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            in_a     = 18'd5;
            in_b     = 18'd5;
            tick();
        end
        in_valid = 1'b0;
        check("drain_busy", 64'(busy[0]), 64'd1);
        #1;
        RST_N = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy[0]), 64'd0);
        check("mid_rst_rstm", 64'(rstm[0]), 64'd1);
        check("mid_rst_rstp", 64'(rstp[1]), 64'd1);
        check("mid_rst_result", 64'(result[1]), 64'd0);
        check("mid_rst_ovf", 64'(ovf[1]), 64'd0);
        check("mid_rst_cem", 64'(cem[0]), 64'd0);
        check("mid_rst_opmode", 64'(opmode[0]), 64'd0);
        check("mid_rst_rv", 64'(rv[0]), 64'd0);
        repeat (2) tick();
        #2;
        RST_N = 1'b1;
        #1;
        check("rel_rstm_hold", 64'(rstm[1]), 64'd1);
        tick();
        check("rel_rstm_drop", 64'(rstm[1]), 64'd0);
        tick();

        // start and abort together in IDLE: start wins
        pa[0] = 18'd3; pb[0] = 18'd3;
        run_job(1, 0, 1'b0, 1'b0, 1'b0, 1'b1);

        repeat (3) tick();
        check("sb0_drained", 64'(sb0.size()), 64'd0);
        check("sb1_drained", 64'(sb1.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
